// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-word adder.
// Provides the CLA core width macro `N (default 8), the default word count
// and the two-state sequencing encoding.
`ifndef N
`define N 8
`endif

package multiword_add_seq_pkg;

   // Width of the carry-lookahead core; the sequencer word width must match.
   localparam int CLA_W = `N;

   // Maximum words per operation when the instantiator does not override it.
   localparam int DEFAULT_WORDS = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/multiword_add_seq_cla.sv
// Combinational W-bit carry-lookahead adder core.
// Every carry is formed directly from generate/propagate terms and the
// carry-in, so no carry ripples through earlier sum bits.
module multiword_add_seq_cla #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);

   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;
   logic         acc;
   logic         term;

   assign gen  = a_i & b_i;
   assign prop = a_i ^ b_i;

   // Lookahead carries: c[i+1] = OR_j (g[j] & p[j+1..i]) | (cin & p[0..i])
   always_comb begin
      carry    = '0;
      acc      = 1'b0;
      term     = 1'b0;
      carry[0] = cin_i;
      for (int i = 0; i < W; i++) begin
         acc = cin_i;
         for (int j = 0; j <= i; j++) begin
            acc = acc & prop[j];
         end
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & prop[k];
            end
            acc = acc | term;
         end
         carry[i+1] = acc;
      end
   end

   assign sum_o  = prop ^ carry[W-1:0];
   assign cout_o = carry[W];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-precision adder: one W-bit word pair per beat, LS word
// first, chained carry between beats through a single CLA core.
// Optional macro MWA_SUB_EN adds in_sub_i for A - B (two's complement:
// B inverted on every word, first-word carry forced to 1).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for the first word; carry-in comes from in_cin_i
// ST_RUN  | mid-operation; carry-in comes from carry_q, idx from cnt_q
`ifndef N
`define N 8
`endif

module multiword_add_seq
   import multiword_add_seq_pkg::*;
#(
   parameter int W     = `N,
   parameter int WORDS = DEFAULT_WORDS,
   parameter int CW    = $clog2(WORDS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [W-1:0]  in_a_i,
   input  logic [W-1:0]  in_b_i,
   input  logic          in_cin_i,
   input  logic          in_last_i,
`ifdef MWA_SUB_EN
   input  logic          in_sub_i,
`endif
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [W-1:0]  out_sum_o,
   output logic [CW-1:0] out_idx_o,
   output logic          out_last_o,
   output logic          out_cout_o,
   output logic          out_err_o
);

   localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          carry_q;
   logic          out_valid_q;
   logic [W-1:0]  out_sum_q;
   logic [CW-1:0] out_idx_q;
   logic          out_last_q;
   logic          out_cout_q;
   logic          out_err_q;
`ifdef MWA_SUB_EN
   logic          sub_q;
`endif

   logic          accept;
   logic          first_beat;
   logic [CW-1:0] cur_idx;
   logic          at_max;
   logic          end_op;
   logic          sub_eff;
   logic [W-1:0]  core_b;
   logic          core_cin;
   logic [W-1:0]  core_sum;
   logic          core_cout;

   // Single output register with no skid buffer: accept only when the
   // slot is empty or is being drained this cycle.
   assign in_ready_o = ~out_valid_q | out_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   assign first_beat = (state_q == ST_IDLE);
   assign cur_idx    = first_beat ? '0 : cnt_q;
   assign at_max     = (cur_idx == LAST_IDX);
   assign end_op     = in_last_i | at_max;

`ifdef MWA_SUB_EN
   assign sub_eff = first_beat ? in_sub_i : sub_q;
`else
   assign sub_eff = 1'b0;
`endif

   assign core_b   = sub_eff ? ~in_b_i : in_b_i;
   // A subtract forces the first-word carry to 1 regardless of in_cin_i.
   assign core_cin = first_beat ? (sub_eff | in_cin_i) : carry_q;

   multiword_add_seq_cla #(
      .W (W)
   ) u_cla (
      .a_i    (in_a_i),
      .b_i    (core_b),
      .cin_i  (core_cin),
      .sum_o  (core_sum),
      .cout_o (core_cout)
   );

   // Sequencer: state, word counter, carry chain and registered result beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         out_err_q   <= 1'b0;
`ifdef MWA_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= core_sum;
            out_idx_q   <= cur_idx;
            out_last_q  <= end_op;
            out_cout_q  <= end_op & core_cout;
            // Hitting the word limit without in_last is a forced stop.
            out_err_q   <= at_max & ~in_last_i;
            carry_q     <= core_cout;
`ifdef MWA_SUB_EN
            if (first_beat) begin
               sub_q <= in_sub_i;
            end
`endif
            if (end_op) begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end else begin
               state_q <= ST_RUN;
               cnt_q   <= cur_idx + CW'(1);
            end
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_sum_o   = out_sum_q;
   assign out_idx_o   = out_idx_q;
   assign out_last_o  = out_last_q;
   assign out_cout_o  = out_cout_q;
   assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (W=8, WORDS=4).
// Reference: operands accumulated as whole integers; each result word is a
// slice of A + B + cin (or A + ~B + 1 when subtracting).
module tb_multiword_add_seq;

   localparam int W     = 8;
   localparam int WORDS = 4;
   localparam int CW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_cin = 1'b0;
   logic          in_last = 1'b0;
`ifdef MWA_SUB_EN
   logic          in_sub = 1'b0;
`endif
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_sum;
   logic [CW-1:0] out_idx;
   logic          out_last;
   logic          out_cout;
   logic          out_err;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   int            op_n = 0;
   logic [63:0]   acc_a = '0;
   logic [63:0]   acc_b = '0;
   logic          op_cin = 1'b0;
   logic          op_sub = 1'b0;
   logic [W-1:0]  last_es = '0;
   logic [CW-1:0] last_ei = '0;

   multiword_add_seq #(
      .W     (W),
      .WORDS (WORDS),
      .CW    (CW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_cin_i    (in_cin),
      .in_last_i   (in_last),
`ifdef MWA_SUB_EN
      .in_sub_i    (in_sub),
`endif
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .out_idx_o   (out_idx),
      .out_last_o  (out_last),
      .out_cout_o  (out_cout),
      .out_err_o   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      op_n  = 0;
      acc_a = '0;
      acc_b = '0;
   endtask

   task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic last, input logic sub,
                             output logic [W-1:0] es, output logic [CW-1:0] ei,
                             output logic el, output logic ec, output logic ee);
      logic [63:0] mask;
      logic [63:0] bop;
      logic [63:0] total;
      if (op_n == 0) begin
         op_cin = cin;
         op_sub = sub;
         acc_a  = '0;
         acc_b  = '0;
      end
      acc_a = acc_a | (64'(a) << (8 * op_n));
      acc_b = acc_b | (64'(b) << (8 * op_n));
      mask  = (64'd1 << (8 * (op_n + 1))) - 64'd1;
      bop   = op_sub ? (~acc_b & mask) : acc_b;
      total = acc_a + bop + (op_sub ? 64'd1 : 64'(op_cin));
      es = total[8*op_n +: 8];
      ei = CW'(op_n);
      el = last || (op_n == WORDS - 1);
      ee = (op_n == WORDS - 1) && !last;
      ec = el ? total[8*(op_n+1)] : 1'b0;
      op_n = el ? 0 : op_n + 1;
   endtask

   task automatic do_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic last, input logic sub);
      int n;
      logic [W-1:0]  es;
      logic [CW-1:0] ei;
      logic el, ec, ee;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_last  = last;
`ifdef MWA_SUB_EN
      in_sub   = sub;
`endif
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      model_beat(a, b, cin, last, sub, es, ei, el, ec, ee);
      last_es = es;
      last_ei = ei;
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_sum",   64'(out_sum),   64'(es));
      chk("out_idx",   64'(out_idx),   64'(ei));
      chk("out_last",  64'(out_last),  64'(el));
      chk("out_cout",  64'(out_cout),  64'(ec));
      chk("out_err",   64'(out_err),   64'(ee));
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_sum"},   64'(out_sum),   64'd0);
      chk({tag, "_idx"},   64'(out_idx),   64'd0);
      chk({tag, "_last"},  64'(out_last),  64'd0);
      chk({tag, "_cout"},  64'(out_cout),  64'd0);
      chk({tag, "_err"},   64'(out_err),   64'd0);
      chk({tag, "_ready"}, 64'(in_ready),  64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      logic sub_r;
      // reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_values("reset");

      // 16-bit add 0x12FF + 0x0001
      do_beat(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      do_beat(8'h12, 8'h00, 1'b0, 1'b1, 1'b0);

      // 32-bit 0xFFFFFFFF + 1
      do_beat(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      do_beat(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      do_beat(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      do_beat(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);

      // backpressure: hold the first result for 3 cycles with beat 2 offered
      do_beat(8'hC7, 8'h5A, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_a     = 8'h80;
         in_b     = 8'h7F;
         in_cin   = 1'b0;
         in_last  = 1'b0;
         chk("bp_ready", 64'(in_ready),  64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_sum",   64'(out_sum),   64'(last_es));
         chk("bp_idx",   64'(out_idx),   64'(last_ei));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      do_beat(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
      do_beat(8'h3C, 8'hC4, 1'b0, 1'b1, 1'b0);

      // overrun: five beats without in_last, later in_cin values ignored in RUN
      do_beat(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_beat(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
      end
      chk("ovr_sum5", 64'(out_sum), 64'h03);

      // reset in the middle of a 4-word operation
      do_beat(8'hAA, 8'h77, 1'b1, 1'b0, 1'b0);
      do_beat(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_values("midrst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      do_beat(8'h05, 8'h03, 1'b1, 1'b1, 1'b0);
      chk("midrst_sum09", 64'(out_sum), 64'h09);

`ifdef MWA_SUB_EN
      // 0x0100 - 0x0001
      do_beat(8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
      do_beat(8'h01, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("sub_cout", 64'(out_cout), 64'd1);
`endif

      // randomized operations with idle gaps between words
      for (int op = 0; op < 30; op++) begin
         len   = $urandom_range(1, 5);
         sub_r = 1'b0;
`ifdef MWA_SUB_EN
         sub_r = 1'($urandom_range(0, 1));
`endif
         for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_beat(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    (k == len - 1), sub_r);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
- Sequential multi-precision adder that wraps the `N-bit carry-lookahead adder core.
- Accepts wide operands one W-bit word per beat, least-significant word first.
- Feeds each word pair plus a chained carry into the CLA core, registers the sum word, and carries the carry-out into the next beat.
- Sits between the operand source (valid/ready stream) and the result consumer. This lets the team add operands wider than `N without widening the lookahead logic.

Parameters:
- W, default `N (8), word width; must equal the CLA core width.
- WORDS, default 4, maximum words per operation; values ≥ 2.
- CW, default $clog2(WORDS), width of the word counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_a  input  W  operand A word.
- in_b  input  W  operand B word.
- in_cin  input  1  carry-in; sampled only on the first beat of an operation.
- in_last  input  1  final word of the operation.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- out_sum  output  W  sum word.
- out_idx  output  CW  word index of out_sum, 0 = least significant word.
- out_last  output  1  final word of the operation.
- out_cout  output  1  carry-out of the final word; 0 when out_last=0.
- out_err  output  1  length overrun on this beat.

Behaviour:
- Reset (asynchronous, active-high) forces: out_valid=0, out_sum=0, out_idx=0, out_last=0, out_cout=0, out_err=0, carry register=0, word counter=0, state=IDLE. in_ready=1 after reset.
- Handshake:
  - A beat transfers when valid&ready.
  - in_ready = !out_valid | out_ready (single output register, no skid buffer).
  - out_* is held stable while out_valid=1 and out_ready=0.
- Latency: 1 cycle from input acceptance to out_valid. Full throughput of 1 word per cycle with out_ready held high.
- State machine:
  - IDLE (awaiting first word):
    - On acceptance, the core carry-in is in_cin.
    - Beat gets idx=0.
    - If in_last=1, stay in IDLE; else go to RUN.
  - RUN:
    - On acceptance, the core carry-in is the carry register; in_cin is ignored.
    - idx = counter.
    - If in_last=1, or counter==WORDS-1, return to IDLE and clear the counter.
- Carry register: loaded with the core carry-out on every accepted beat. Not consulted in IDLE.
- out_last: set when in_last=1 or counter==WORDS-1.
- out_err: set when counter==WORDS-1 and in_last=0 (forced termination). The next beat starts a new operation from IDLE.
- out_cout: equals the core carry-out on the out_last beat, else 0.
- Arithmetic: out_sum = (in_a + in_b + cin) mod 2^W, computed by the CLA sub-instance. There is no additional adder in this block.
- Reset mid-operation: the partial operation is discarded, and the next accepted beat is treated as a first word.
- in_valid low between words in RUN: the carry and counter are held indefinitely; no timeout.

Optional Feature:
- Macro: MWA_SUB_EN.
- Defined: adds input port in_sub (1 bit), sampled on the first beat and held for the whole operation.
  - When set, the core B input is ~in_b on every word, and the first-word carry-in is forced to 1 (in_cin ignored).
  - out_cout=1 means no borrow.
- Undefined: no in_sub port; addition only.

Decomposition:
- Shared package/header (alongside params.vh):
  - State encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
  - Default WORDS.
  - The `N width macro, reused for W.
- One sub-module: the existing CLA core, instantiated once, combinational.
- All sequencing lives in multiword_add_seq.

Test Plan (W=8, WORDS=4):
- 16-bit add 0x12FF+0x0001, cin=0, beats (FF,01),(12,00,last):
  - out (00, idx0), then (13, idx1, last, cout=0).
- 32-bit 0xFFFFFFFF+0x00000001:
  - out 00,00,00,00 at idx 0..3, last on idx3, cout=1, err=0.
- Backpressure: out_ready=0 for 3 cycles after the first result:
  - in_ready=0 and out_sum/out_idx stable.
  - The sequence resumes with the correct carry.
- Overrun: 5 beats of (01,01) with in_last=0:
  - idx3 beat has out_last=1, err=1.
  - 5th beat has idx0, carry-in from in_cin.
- Reset mid-op: assert rst after 2 of 4 beats:
  - outputs return to reset values at once.
  - Next beat (05,03,cin=1,last) gives sum 09, idx0, cout=0.
- With MWA_SUB_EN, in_sub=1, 0x0100−0x0001:
  - out FF idx0, then 00 idx1 last, cout=1.
